// File: rtl/serial_pkg.sv
// +--------------------------------------------------------------------+
// | serial_pkg: shared state encoding and line levels for serial links |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_tx_if.sv
// +--------------------------------------------------------------------+
// | serial_frame_tx_if: load handshake and serial line of transmitter  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] DIN;
  logic              LOAD;
  logic              READY;
  logic              TXD;
  logic              TXD_n;
  logic              DONE;

  modport master (
    output DIN, LOAD,
    input  READY, TXD, TXD_n, DONE
  );

  modport slave (
    input  DIN, LOAD,
    output READY, TXD, TXD_n, DONE
  );

endinterface

`default_nettype wire

// File: rtl/bit_timer.sv
// +--------------------------------------------------------------------+
// | bit_timer: counts CLKS_PER_BIT clocks, ticks on each bit boundary  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int            CW   = min1_clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  // Tick marks the final cycle of a bit so the owner can advance on that edge.
  assign tick_o = enable_i && (cnt_q == LAST);

  always_ff @(posedge CLK) begin
    if (RST || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// +--------------------------------------------------------------------+
// | serial_frame_tx: start/data(LSB first)/[parity]/stop transmitter;  |
// | even parity compiled in with SERIAL_FRAME_TX_PARITY_EN.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  serial_frame_tx_if.slave  bus
);

  localparam int            IW       = min1_clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [IW-1:0]     idx_q;
  logic              txd_q;
  logic              txdn_q;
  logic              ready_q;
  logic              done_q;
  logic              w_tick;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              parity_q;
`endif

  assign w_shift_nxt = shift_q >> 1;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear_i  (state_q == S_IDLE),
    .enable_i (state_q != S_IDLE),
    .tick_o   (w_tick)
  );

  // Line levels are set on the edge that enters each bit, keeping TXD a pure flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      txd_q    <= LINE_IDLE;
      txdn_q   <= ~LINE_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.LOAD) begin
            shift_q  <= bus.DIN;
            idx_q    <= '0;
            txd_q    <= START_BIT;
            txdn_q   <= ~START_BIT;
            ready_q  <= 1'b0;
            state_q  <= S_START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q <= ^bus.DIN;
`endif
          end
        end
        S_START: begin
          if (w_tick) begin
            txd_q   <= shift_q[0];
            txdn_q  <= ~shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (idx_q == LAST_IDX) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
              txd_q   <= parity_q;
              txdn_q  <= ~parity_q;
              state_q <= S_PARITY;
`else
              txd_q   <= STOP_BIT;
              txdn_q  <= ~STOP_BIT;
              state_q <= S_STOP;
`endif
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= w_shift_nxt;
              txd_q   <= w_shift_nxt[0];
              txdn_q  <= ~w_shift_nxt[0];
            end
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            txd_q   <= STOP_BIT;
            txdn_q  <= ~STOP_BIT;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            txd_q   <= LINE_IDLE;
            txdn_q  <= ~LINE_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          txd_q   <= LINE_IDLE;
          txdn_q  <= ~LINE_IDLE;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.TXD   = txd_q;
  assign bus.TXD_n = txdn_q;
  assign bus.READY = ready_q;
  assign bus.DONE  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// +--------------------------------------------------------------------+
// | tb_serial_frame_tx: scoreboard bench, CLKS_PER_BIT=4 and =1 DUTs   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_A = NBITS * 4;
  localparam int FRAME_B = NBITS * 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_frame_tx_if #(.DATA_W(8)) bus_a ();
  serial_frame_tx_if #(.DATA_W(8)) bus_b ();

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (bus_a)
  );

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit qa[$];
  bit qb[$];
  int lowa = 0, lowb = 0;
  int donea = 0, doneb = 0;
  int last_done_a = 0, gap_a = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line level for every clock of one frame.
  task automatic push_frame(input logic [7:0] d, input int cpb, input bit to_b);
    bit seq[$];
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(d[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    seq.push_back(^d);
`endif
    seq.push_back(1'b1);
    foreach (seq[k]) begin
      for (int r = 0; r < cpb; r++) begin
        if (to_b) qb.push_back(seq[k]);
        else      qa.push_back(seq[k]);
      end
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      lowa = 0;
    end else begin
      chk("txd_n_a", int'(bus_a.TXD_n), int'(!bus_a.TXD));
      if (!bus_a.READY) begin
        lowa++;
        if (qa.size() == 0) chk("extra_bit_a", 1, 0);
        else                chk("txd_a", int'(bus_a.TXD), int'(qa.pop_front()));
      end else begin
        chk("idle_txd_a", int'(bus_a.TXD), 1);
      end
      if (bus_a.DONE) begin
        donea++;
        chk("frame_len_a", lowa, FRAME_A);
        lowa = 0;
        gap_a = cyc - last_done_a;
        last_done_a = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      lowb = 0;
    end else begin
      chk("txd_n_b", int'(bus_b.TXD_n), int'(!bus_b.TXD));
      if (!bus_b.READY) begin
        lowb++;
        if (qb.size() == 0) chk("extra_bit_b", 1, 0);
        else                chk("txd_b", int'(bus_b.TXD), int'(qb.pop_front()));
      end
      if (bus_b.DONE) begin
        doneb++;
        chk("ready_low_b", lowb, FRAME_B);
        lowb = 0;
      end
    end
  end

  task automatic load_a(input logic [7:0] d, input bit keep);
    int t = 0;
    @(negedge clk);
    bus_a.DIN  = d;
    bus_a.LOAD = 1'b1;
    while (!bus_a.READY && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("load_timeout_a", 0, 1);
    else          push_frame(d, 4, 1'b0);
    @(posedge clk);
    #1;
    if (!keep) bus_a.LOAD = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] d);
    @(negedge clk);
    bus_b.DIN  = d;
    bus_b.LOAD = 1'b1;
    if (!bus_b.READY) chk("ready_b_before_load", 0, 1);
    else              push_frame(d, 1, 1'b1);
    @(posedge clk);
    #1;
    bus_b.LOAD = 1'b0;
  endtask

  task automatic wait_done_a(input int n);
    int t = 0;
    while (donea < n && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (donea < n) chk("done_timeout_a", donea, n);
  endtask

  task automatic wait_done_b(input int n);
    int t = 0;
    while (doneb < n && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (doneb < n) chk("done_timeout_b", doneb, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus_a.DIN = 8'h00; bus_a.LOAD = 1'b0;
    bus_b.DIN = 8'h00; bus_b.LOAD = 1'b0;

    // Power-on reset values
    @(negedge clk);
    chk("rst_txd_a",   int'(bus_a.TXD),   1);
    chk("rst_txdn_a",  int'(bus_a.TXD_n), 0);
    chk("rst_ready_a", int'(bus_a.READY), 1);
    chk("rst_done_a",  int'(bus_a.DONE),  0);
    chk("rst_txd_b",   int'(bus_b.TXD),   1);
    chk("rst_ready_b", int'(bus_b.READY), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frames: A5 and 07
    d0 = donea;
    load_a(8'hA5, 1'b0);
    wait_done_a(d0 + 1);
    repeat (5) @(negedge clk);
    d0 = donea;
    load_a(8'h07, 1'b0);
    wait_done_a(d0 + 1);
    repeat (5) @(negedge clk);

    // Busy ignore: LOAD with FF during a frame of 00
    d0 = donea;
    load_a(8'h00, 1'b0);
    repeat (8) @(negedge clk);
    bus_a.DIN  = 8'hFF;
    bus_a.LOAD = 1'b1;
    @(negedge clk);
    bus_a.LOAD = 1'b0;
    wait_done_a(d0 + 1);
    repeat (60) @(negedge clk);
    chk("busy_single_done", donea, d0 + 1);
    chk("busy_queue_empty", qa.size(), 0);

    // Back-to-back: frame period is the frame plus the one-cycle handshake
    d0 = donea;
    load_a(8'h3C, 1'b1);
    load_a(8'hC3, 1'b0);
    wait_done_a(d0 + 2);
    chk("b2b_done_gap", gap_a, FRAME_A + 1);
    repeat (5) @(negedge clk);

    // Reset mid-frame: line idles on the first reset edge, no DONE follows
    d0 = donea;
    load_a(8'hA5, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    qa.delete();
    chk("midrst_txd",   int'(bus_a.TXD),   1);
    chk("midrst_txdn",  int'(bus_a.TXD_n), 0);
    chk("midrst_ready", int'(bus_a.READY), 1);
    chk("midrst_done",  int'(bus_a.DONE),  0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_no_done", donea, d0);

    // CLKS_PER_BIT = 1
    d0 = doneb;
    load_b(8'h80);
    wait_done_b(d0 + 1);
    repeat (3) @(negedge clk);
    load_b(8'hA5);
    wait_done_b(d0 + 2);
    repeat (3) @(negedge clk);
    chk("b_queue_empty", qb.size(), 0);
    chk("b_done_count", doneb, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
